vga_dir_input: RTL and testbench

Upstream conditioner for the sprite-movement inputs of the VGA controller. It takes four raw, active-low pushbuttons, synchronises and debounces each one, then resolves them to at most one active direction. It drives the controller's right/left/up/down level inputs directly. It also produces a one-cycle step strobe with hold-to-repeat timing, for consumers that move on events rather than sampling levels.

---
 rtl/vga_input_pkg.sv | 32 +++
 rtl/key_debounce.sv | 42 ++++
 rtl/vga_dir_input.sv | 131 +++++++++++++
 tb/tb_vga_dir_input.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/vga_input_pkg.sv
// Shared encodings for the VGA direction-input conditioner: direction codes,
// step FSM states, and the fixed right > left > up > down priority helpers.
package vga_input_pkg;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } step_state_e;

  // One-hot of the winning pressed key; bit0 right .. bit3 down.
  function automatic logic [3:0] resolve(input logic [3:0] pressed);
    if (pressed[0])      return 4'b0001;
    else if (pressed[1]) return 4'b0010;
    else if (pressed[2]) return 4'b0100;
    else if (pressed[3]) return 4'b1000;
    else                 return 4'b0000;
  endfunction

  function automatic logic [1:0] onehot_dir(input logic [3:0] oh);
    if (oh[0])      return DIR_RIGHT;
    else if (oh[1]) return DIR_LEFT;
    else if (oh[2]) return DIR_UP;
    else            return DIR_DOWN;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One active-low key: 2-flop synchroniser followed by a stability counter.
// Exposes the next-state stable level so the consumer's register lands on the same edge.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 24
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic pressed_nxt_o
);

  logic             s1_q, s2_q, stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample agreeing with the stable level restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) stable_d = s2_q;
      else                                      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      s1_q     <= key_ni;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pressed_nxt_o = ~stable_d;

endmodule

// File: rtl/vga_dir_input.sv
// Debounced, priority-resolved direction levels plus a one-cycle step strobe.
// Define DIR_AUTOREPEAT_EN for hold-to-repeat strobes (REPEAT_DELAY/REPEAT_RATE >= 2).
module vga_dir_input
  import vga_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_RATE     = 200000,
  parameter int CNT_W           = 24
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic [3:0] iKEY_n,
  output logic       right,
  output logic       left,
  output logic       up,
  output logic       down,
  output logic       oStep,
  output logic [1:0] oDir
);

  logic [3:0]  press_nxt, lvl_q;
  step_state_e state_q, state_d;
  logic        step_q, step_d, active, can_fire;
  logic [1:0]  dir_q, dir_d, d;
`ifdef DIR_AUTOREPEAT_EN
  logic [CNT_W-1:0] rcnt_q, rcnt_d, rlim;
`endif

  for (genvar g = 0; g < 4; g++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_key (
      .clk_i        (iVGA_CLK),
      .rst_ni       (iRST_n),
      .key_ni       (iKEY_n[g]),
      .pressed_nxt_o(press_nxt[g])
    );
  end

  assign active   = |lvl_q;
  assign d        = onehot_dir(lvl_q);
  // A pending strobe waits one cycle so oStep never stays high back-to-back.
  assign can_fire = ~step_q;
`ifdef DIR_AUTOREPEAT_EN
  assign rlim = (state_q == HOLD) ? CNT_W'(REPEAT_DELAY - 1) : CNT_W'(REPEAT_RATE - 1);
`endif

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      lvl_q   <= '0;
      state_q <= IDLE;
      step_q  <= 1'b0;
      dir_q   <= DIR_RIGHT;
`ifdef DIR_AUTOREPEAT_EN
      rcnt_q  <= '0;
`endif
    end else begin
      lvl_q   <= resolve(press_nxt);
      state_q <= state_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
`ifdef DIR_AUTOREPEAT_EN
      rcnt_q  <= rcnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (active && can_fire) state_d = HOLD;
      HOLD: begin
        if (!active) state_d = IDLE;
`ifdef DIR_AUTOREPEAT_EN
        else if (d == dir_q && rcnt_q == rlim && can_fire) state_d = REPEAT;
`endif
      end
`ifdef DIR_AUTOREPEAT_EN
      REPEAT: begin
        if (!active)                        state_d = IDLE;
        else if (d != dir_q && can_fire)    state_d = HOLD;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    step_d = 1'b0;
    dir_d  = dir_q;
`ifdef DIR_AUTOREPEAT_EN
    rcnt_d = rcnt_q;
`endif
    if (state_q == IDLE) begin
      if (active && can_fire) begin
        step_d = 1'b1;
        dir_d  = d;
`ifdef DIR_AUTOREPEAT_EN
        rcnt_d = '0;
`endif
      end
    end else if (active) begin
      if (d != dir_q) begin
        if (can_fire) begin
          step_d = 1'b1;
          dir_d  = d;
`ifdef DIR_AUTOREPEAT_EN
          rcnt_d = '0;
`endif
        end
      end
`ifdef DIR_AUTOREPEAT_EN
      else if (rcnt_q == rlim) begin
        if (can_fire) begin
          step_d = 1'b1;
          rcnt_d = '0;
        end
      end else begin
        rcnt_d = rcnt_q + CNT_W'(1);
      end
`endif
    end
  end

  assign right = lvl_q[0];
  assign left  = lvl_q[1];
  assign up    = lvl_q[2];
  assign down  = lvl_q[3];
  assign oStep = step_q;
  assign oDir  = dir_q;

endmodule

// File: tb/tb_vga_dir_input.sv
// Directed + random key stimulus against a window/timestamp reference model.
module tb_vga_dir_input;
  localparam int D    = 4;
  localparam int RD   = 10;
  localparam int RR   = 3;
  localparam int MAXN = 4096;
`ifdef DIR_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_n = 4'h0;
  logic       right, left, up, down, step;
  logic [1:0] dir;

  always #5 clk = ~clk;

  vga_dir_input #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(8)) dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iKEY_n(key_n),
    .right(right), .left(left), .up(up), .down(down), .oStep(step), .oDir(dir)
  );

  int vectors = 0, miscompares = 0;

  // Model: raw/synchronised key history per edge since reset release.
  logic [3:0] raw_h [0:MAXN];
  logic [3:0] s2_h  [0:MAXN];
  logic [3:0] stab;
  int         lastflip [4];
  int         n;
  logic [3:0] lvl_m;
  logic       step_m;
  logic [1:0] dir_m;
  bit         idle_m, first_m;
  int         t_m;

  task automatic model_reset();
    n = 0;
    raw_h[0] = 4'hF;
    s2_h[0]  = 4'hF;
    stab = 4'hF;
    for (int i = 0; i < 4; i++) lastflip[i] = 0;
    lvl_m = '0; step_m = 1'b0; dir_m = 2'd0;
    idle_m = 1'b1; first_m = 1'b1; t_m = 0;
  endtask

  task automatic model_edge(input logic [3:0] k);
    logic [1:0] dp;
    logic [3:0] pressed;
    bit act, s, flip, found;
    n++;
    raw_h[n] = k;
    s2_h[n]  = raw_h[n-1];
    // strobe decision uses the level outputs visible before this edge
    act = |lvl_m;
    dp = 2'd0;
    for (int i = 3; i >= 0; i--) if (lvl_m[i]) dp = 2'(i);
    s = 1'b0;
    if (!act) idle_m = 1'b1;
    else if (idle_m) begin
      s = 1'b1; idle_m = 1'b0; dir_m = dp; t_m = n; first_m = 1'b1;
    end else if (dp != dir_m) begin
      if (!step_m) begin s = 1'b1; dir_m = dp; t_m = n; first_m = 1'b1; end
    end else if (AR && (n - t_m) == (first_m ? RD : RR)) begin
      s = 1'b1; t_m = n; first_m = 1'b0;
    end
    step_m = s;
    // a key flips once its synchronised value has disagreed for D straight edges
    for (int i = 0; i < 4; i++) begin
      if (n - D >= lastflip[i]) begin
        flip = 1'b1;
        for (int j = n - D; j < n; j++) if (s2_h[j][i] == stab[i]) flip = 1'b0;
        if (flip) begin stab[i] = ~stab[i]; lastflip[i] = n; end
      end
    end
    pressed = ~stab;
    lvl_m = '0;
    found = 1'b0;
    for (int i = 0; i < 4; i++)
      if (pressed[i] && !found) begin lvl_m[i] = 1'b1; found = 1'b1; end
  endtask

  task automatic check(input string tag);
    logic [6:0] got, exp;
    got = {down, up, left, right, step, dir};
    exp = {lvl_m, step_m, dir_m};
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s n=%0d got=%b exp=%b (dlur/step/dir)", tag, n, got, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] k, input string tag);
    key_n = k;
    @(posedge clk);
    model_edge(k);
    #1 check(tag);
  endtask

  int nstep;

  initial begin
    model_reset();
    key_n = 4'h0;
    repeat (3) @(posedge clk);
    #1 check("reset_hold");
    rst_n = 1'b1;
    repeat (20) cyc(4'h0, "reset_release");
    repeat (20) cyc(4'hF, "release_all");
    for (int i = 0; i < 5; i++) begin
      repeat (2) cyc(4'hD, "bounce");
      repeat (2) cyc(4'hF, "bounce");
    end
    repeat (20) cyc(4'hD, "left_hold");
    repeat (20) cyc(4'hF, "release");
    repeat (20) cyc(4'hB, "up_hold");
    repeat (20) cyc(4'hA, "right_over_up");
    repeat (20) cyc(4'hF, "release");
    repeat (40) cyc(4'h7, "down_repeat");
    repeat (20) cyc(4'hF, "down_release");
    repeat (30) cyc(4'h7, "pre_midrst");
    rst_n = 1'b0;
    model_reset();
    #1 check("midrst_async");
    @(posedge clk);
    #1 check("midrst_hold");
    rst_n = 1'b1;
    repeat (40) cyc(4'h7, "post_midrst");
    repeat (20) cyc(4'hF, "release");
    nstep = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(4'hD, "left_50");
      if (step) nstep++;
    end
`ifndef DIR_AUTOREPEAT_EN
    vectors++;
    assert (nstep === 1)
    else begin
      miscompares++;
      $error("FAIL no_repeat_count got=%0d exp=1", nstep);
    end
`endif
    repeat (20) cyc(4'hF, "release");
    for (int seg = 0; seg < 40; seg++) begin
      logic [3:0] k;
      int len;
      k = 4'($urandom);
      if ($urandom_range(0, 1) == 0) k = ~(4'b0001 << $urandom_range(0, 3));
      len = $urandom_range(1, 14);
      repeat (len) cyc(k, "random");
    end
    repeat (20) cyc(4'hF, "final_release");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
